sum_checker: RTL and testbench
==============================

Name: sum_checker

Overview:
Self-checking sink for the parameterised adder path. It consumes the operand/sum stream that the stimulus counter and adder produce, and recomputes each sum at full width. It also verifies that the operand sequence increments by one per sample, then reports pass/fail, an error count and the first failing sample. It sits on the adder output side, so benches and on-chip BIST can judge the adder without $display inspection.

Parameters:
WIDTH, 6, operand width; the sum is WIDTH+1 bits.
NUM_SAMPLES, 32, samples accepted per run (1..2^WIDTH).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  reset, asynchronous, active-low.
start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
in_valid  input  1  sample present on in_a/in_b/in_sum.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sum  input  WIDTH+1  DUT sum under check.
in_ready  output  1  checker accepts a sample this cycle.
busy  output  1  state is RUN.
done  output  1  state is DONE; held until the next start.
pass  output  1  valid when done: err_count==0 and seq_err==0.
err_count  output  ERR_W  sum mismatches; saturates at all-ones.
seq_err  output  1  sticky; in_a differed from the expected index.
first_err_idx  output  WIDTH  index of the first sum mismatch.
first_err_sum  output  WIDTH+1  in_sum captured at the first mismatch.
first_err_valid  output  1  a first error has been captured.

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0; internal index idx=0.
- States IDLE, RUN, DONE; the state register is the only control.
- IDLE: in_ready=0. start -> RUN next cycle. On that transition idx, err_count, seq_err and first_err_* clear to 0.
- RUN: in_ready=1, busy=1. Accept = in_valid & in_ready.
  - On accept, expected = {1'b0,in_a} + {1'b0,in_b}, computed at WIDTH+1 bits with no truncation.
  - If in_sum != expected: err_count increments unless already all-ones. If first_err_valid==0, capture first_err_idx=idx and first_err_sum=in_sum, and set first_err_valid.
  - If in_a != idx[WIDTH-1:0]: seq_err set (sticky).
  - idx increments on each accept. idx is WIDTH+1 bits wide, so NUM_SAMPLES=2^WIDTH does not wrap early.
  - Accepting the sample with idx==NUM_SAMPLES-1 -> DONE next cycle.
- Latency: all status outputs are registered and reflect an accepted sample 1 cycle after the accept edge. done rises in the same cycle that the last sample's error update becomes visible.
- DONE: in_ready=0, done=1, pass=(err_count==0)&&!seq_err. Status holds. start -> RUN with a clear, as from IDLE.
- start while RUN: ignored; the run continues.
- in_valid while IDLE or DONE: ignored; no state change.
- rstn asserted mid-run: immediate return to IDLE with all outputs 0; the partial run is discarded.
- A start coinciding with the final accept is impossible (start is ignored in RUN).

Decomposition:
- Shared package sum_checker_pkg: state encoding constants (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and an error-counter saturation helper function.
- One natural sub-module, sat_counter (ERR_W param; inc, clr, value). It is reusable for the other checker counters.
- The comparator stays inline.

Test Plan:
- Reset, start, 32 samples with in_a=in_b=0..31 and correct sum=2*i -> done=1 one cycle after the 32nd accept; pass=1, err_count=0, seq_err=0.
- Same run, but sample 5 drives in_sum=11 (expected 10) -> err_count=1, first_err_idx=5, first_err_sum=11, pass=0.
- Boundary: in_a=63, in_b=63, in_sum=126 accepted as correct (no truncation to 62). A separate NUM_SAMPLES=64 run reaches DONE only after 64 accepts.
- Sequence: skip index 7 (send 6, then 8) -> seq_err=1, err_count=0, pass=0.
- Saturation (ERR_W=2): 5 bad sums -> err_count=3 and holds; first_err_idx is the first bad index.
- Drop rstn during sample 10 of a run -> outputs go to 0 immediately. A new start then runs cleanly to pass=1; in_valid pulses while IDLE/DONE cause no change.

Source files
------------

// File: rtl/sum_checker_pkg.sv
// Shared types and helpers for the adder-path sum checker.
// Holds the control state encoding and the saturation test used by its counters.
package sum_checker_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Widest counter the saturation helper supports.
   localparam int unsigned SAT_MAX_W = 32;

   // True when value already holds the all-ones code of a width-bit counter.
   function automatic logic sat_at_max(input logic [SAT_MAX_W-1:0] value,
                                       input int unsigned           width);
      logic [SAT_MAX_W-1:0] ones;
      ones = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
      return (value == ones);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Sticks at all-ones once reached until cleared or reset.
module sat_counter
   import sum_checker_pkg::*;
#(
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             inc,
   output logic [ERR_W-1:0] value
);

   logic [ERR_W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc && !sat_at_max(SAT_MAX_W'(value_q), ERR_W)) begin
         value_d = value_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/sum_checker.sv
// Self-checking sink for the adder path: recomputes each sum at full width, checks that
// operand A walks 0,1,2,... and reports pass/fail, a saturating error count and the first miss.
module sum_checker
   import sum_checker_pkg::*;
#(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned NUM_SAMPLES = 32,
   parameter int unsigned ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH:0]   in_sum,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             seq_err,
   output logic [WIDTH-1:0] first_err_idx,
   output logic [WIDTH:0]   first_err_sum,
   output logic             first_err_valid
);

   localparam int unsigned IDX_W = WIDTH + 1;
   // idx is one bit wider than the operand so a full 2^WIDTH run ends on the right sample.
   localparam logic [WIDTH:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

   state_e           state_q, state_d;
   logic [WIDTH:0]   idx_q, idx_d;
   logic             seq_err_q, seq_err_d;
   logic [WIDTH-1:0] first_idx_q, first_idx_d;
   logic [WIDTH:0]   first_sum_q, first_sum_d;
   logic             first_vld_q, first_vld_d;

   logic             run_st;
   logic             start_run;
   logic             accept;
   logic [WIDTH:0]   exp_sum;
   logic             sum_bad;
   logic             seq_bad;

   always_comb begin
      run_st    = (state_q == S_RUN);
      start_run = start && !run_st;
      accept    = in_valid && run_st;
      exp_sum   = {1'b0, in_a} + {1'b0, in_b};
      sum_bad   = accept && (in_sum != exp_sum);
      seq_bad   = accept && (in_a != idx_q[WIDTH-1:0]);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (accept && (idx_q == LAST_IDX)) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d       = idx_q;
      seq_err_d   = seq_err_q;
      first_idx_d = first_idx_q;
      first_sum_d = first_sum_q;
      first_vld_d = first_vld_q;
      if (start_run) begin
         idx_d       = '0;
         seq_err_d   = 1'b0;
         first_idx_d = '0;
         first_sum_d = '0;
         first_vld_d = 1'b0;
      end else if (accept) begin
         idx_d = idx_q + IDX_W'(1);
         if (seq_bad) begin
            seq_err_d = 1'b1;
         end
         if (sum_bad && !first_vld_q) begin
            first_idx_d = idx_q[WIDTH-1:0];
            first_sum_d = in_sum;
            first_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         seq_err_q   <= 1'b0;
         first_idx_q <= '0;
         first_sum_q <= '0;
         first_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         seq_err_q   <= seq_err_d;
         first_idx_q <= first_idx_d;
         first_sum_q <= first_sum_d;
         first_vld_q <= first_vld_d;
      end
   end

   sat_counter #(
      .ERR_W (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (start_run),
      .inc   (sum_bad),
      .value (err_count)
   );

   always_comb begin
      in_ready        = run_st;
      busy            = run_st;
      done            = (state_q == S_DONE);
      pass            = done && (err_count == '0) && !seq_err_q;
      seq_err         = seq_err_q;
      first_err_idx   = first_idx_q;
      first_err_sum   = first_sum_q;
      first_err_valid = first_vld_q;
   end

endmodule

// File: tb/tb_sum_checker.sv
// Bench for sum_checker: three instances (default, 64-sample run, 2-bit error counter)
// driven with directed and randomized sample streams and judged by a run-level model.
module tb_sum_checker;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [2:0]   start_v = '0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W:0]   in_sum = '0;

   logic r0, b0, d0, p0, s0, v0;
   logic [7:0] e0;
   logic [W-1:0] fi0;
   logic [W:0] fs0;
   logic r1, b1, d1, p1, s1, v1;
   logic [7:0] e1;
   logic [W-1:0] fi1;
   logic [W:0] fs1;
   logic r2, b2, d2, p2, s2, v2;
   logic [1:0] e2;
   logic [W-1:0] fi2;
   logic [W:0] fs2;

   sum_checker #(.WIDTH(W), .NUM_SAMPLES(32), .ERR_W(8)) dut0 (
      .clk(clk), .rstn(rstn), .start(start_v[0]), .in_valid(in_valid), .in_a(in_a),
      .in_b(in_b), .in_sum(in_sum), .in_ready(r0), .busy(b0), .done(d0), .pass(p0),
      .err_count(e0), .seq_err(s0), .first_err_idx(fi0), .first_err_sum(fs0),
      .first_err_valid(v0));

   sum_checker #(.WIDTH(W), .NUM_SAMPLES(64), .ERR_W(8)) dut1 (
      .clk(clk), .rstn(rstn), .start(start_v[1]), .in_valid(in_valid), .in_a(in_a),
      .in_b(in_b), .in_sum(in_sum), .in_ready(r1), .busy(b1), .done(d1), .pass(p1),
      .err_count(e1), .seq_err(s1), .first_err_idx(fi1), .first_err_sum(fs1),
      .first_err_valid(v1));

   sum_checker #(.WIDTH(W), .NUM_SAMPLES(32), .ERR_W(2)) dut2 (
      .clk(clk), .rstn(rstn), .start(start_v[2]), .in_valid(in_valid), .in_a(in_a),
      .in_b(in_b), .in_sum(in_sum), .in_ready(r2), .busy(b2), .done(d2), .pass(p2),
      .err_count(e2), .seq_err(s2), .first_err_idx(fi2), .first_err_sum(fs2),
      .first_err_valid(v2));

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int sa [64];
   int sb [64];
   int ss [64];

   logic        o_ready, o_busy, o_done, o_pass, o_seq, o_fval;
   logic [31:0] o_err, o_fidx, o_fsum;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic get_outs(input int sel);
      case (sel)
         0: begin
            o_ready = r0; o_busy = b0; o_done = d0; o_pass = p0; o_seq = s0; o_fval = v0;
            o_err = 32'(e0); o_fidx = 32'(fi0); o_fsum = 32'(fs0);
         end
         1: begin
            o_ready = r1; o_busy = b1; o_done = d1; o_pass = p1; o_seq = s1; o_fval = v1;
            o_err = 32'(e1); o_fidx = 32'(fi1); o_fsum = 32'(fs1);
         end
         default: begin
            o_ready = r2; o_busy = b2; o_done = d2; o_pass = p2; o_seq = s2; o_fval = v2;
            o_err = 32'(e2); o_fidx = 32'(fi2); o_fsum = 32'(fs2);
         end
      endcase
   endtask

   task automatic chk_zero(input int sel, input string tag);
      get_outs(sel);
      chk({tag, ".ready"}, 32'(o_ready), 0);
      chk({tag, ".busy"}, 32'(o_busy), 0);
      chk({tag, ".done"}, 32'(o_done), 0);
      chk({tag, ".pass"}, 32'(o_pass), 0);
      chk({tag, ".err"}, o_err, 0);
      chk({tag, ".seq"}, 32'(o_seq), 0);
      chk({tag, ".fval"}, 32'(o_fval), 0);
      chk({tag, ".fidx"}, o_fidx, 0);
      chk({tag, ".fsum"}, o_fsum, 0);
   endtask

   task automatic fill_lin(input int n);
      for (int i = 0; i < n; i++) begin
         sa[i] = i; sb[i] = i; ss[i] = 2 * i;
      end
   endtask

   task automatic fill_rand(input int n, input int bad_pct, input int seq_pct);
      for (int i = 0; i < n; i++) begin
         sa[i] = ($urandom_range(0, 99) < seq_pct) ? int'($urandom_range(0, 63)) : i % 64;
         sb[i] = $urandom_range(0, 63);
         ss[i] = sa[i] + sb[i];
         if ($urandom_range(0, 99) < bad_pct) begin
            ss[i] = (ss[i] + int'($urandom_range(1, 127))) % 128;
         end
      end
   endtask

   // Run-level model: results follow from the whole sample list, not from cycle behaviour.
   task automatic check_result(input int sel, input int n, input int errw, input string tag);
      int errs, fidx, fsum, maxv;
      bit fval, seq;
      errs = 0; fidx = 0; fsum = 0; fval = 0; seq = 0;
      maxv = (1 << errw) - 1;
      for (int i = 0; i < n; i++) begin
         if (ss[i] != sa[i] + sb[i]) begin
            errs++;
            if (!fval) begin
               fval = 1; fidx = i; fsum = ss[i];
            end
         end
         if (sa[i] != i % 64) seq = 1;
      end
      get_outs(sel);
      chk({tag, ".done"}, 32'(o_done), 1);
      chk({tag, ".busy"}, 32'(o_busy), 0);
      chk({tag, ".ready"}, 32'(o_ready), 0);
      chk({tag, ".err"}, o_err, (errs > maxv) ? maxv : errs);
      chk({tag, ".seq"}, 32'(o_seq), 32'(seq));
      chk({tag, ".fval"}, 32'(o_fval), 32'(fval));
      chk({tag, ".fidx"}, o_fidx, fidx);
      chk({tag, ".fsum"}, o_fsum, fsum);
      chk({tag, ".pass"}, 32'(o_pass), (errs == 0 && !seq) ? 1 : 0);
   endtask

   task automatic run(input int sel, input int n, input bit noise, input string tag);
      int k, cyc;
      @(negedge clk);
      start_v[sel] = 1'b1;
      @(negedge clk);
      start_v = '0;
      get_outs(sel);
      chk({tag, ".run_busy"}, 32'(o_busy), 1);
      chk({tag, ".run_ready"}, 32'(o_ready), 1);
      k = 0; cyc = 0;
      while (k < n && cyc < 4000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         if (noise && $urandom_range(0, 7) == 0) start_v[sel] = 1'b1;
         in_a = W'(sa[k]); in_b = W'(sb[k]); in_sum = (W + 1)'(ss[k]);
         @(negedge clk);
         start_v = '0;
         cyc++;
         if (in_valid) k++;
         if (k < n) begin
            get_outs(sel);
            chk({tag, ".early_done"}, 32'(o_done), 0);
         end
      end
      in_valid = 1'b0;
      chk({tag, ".accepts"}, k, n);
      check_result(sel, n, (sel == 2) ? 2 : 8, tag);
   endtask

   task automatic idle_pulses(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         in_valid = 1'b1;
         in_a = W'($urandom); in_b = W'($urandom); in_sum = (W + 1)'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #3;
      for (int s = 0; s < 3; s++) chk_zero(s, "reset");
      @(negedge clk);
      rstn = 1'b1;

      fill_lin(32);
      run(0, 32, 1'b0, "lin32");

      fill_lin(32);
      ss[5] = 11;
      run(0, 32, 1'b1, "bad5");

      fill_lin(64);
      run(1, 64, 1'b0, "n64_boundary");

      fill_lin(32);
      for (int i = 7; i < 32; i++) begin
         sa[i] = i + 1; sb[i] = i + 1; ss[i] = 2 * (i + 1);
      end
      run(0, 32, 1'b0, "seqskip");

      fill_rand(32, 0, 0);
      for (int j = 0; j < 5; j++) begin
         ss[3 + 6 * j] = (sa[3 + 6 * j] + sb[3 + 6 * j] + int'($urandom_range(1, 127))) % 128;
      end
      run(2, 32, 1'b0, "sat2");
      idle_pulses(4);
      check_result(2, 32, 2, "sat2_hold");

      for (int r = 0; r < 4; r++) begin
         fill_rand(32, 20, (r == 3) ? 5 : 0);
         run(0, 32, 1'b1, $sformatf("rand%0d", r));
      end
      fill_rand(64, 10, 0);
      run(1, 64, 1'b1, "rand64");

      idle_pulses(5);
      check_result(1, 64, 8, "done_hold");

      // Abort a run part way through sample 10 with asynchronous reset.
      fill_rand(32, 50, 0);
      ss[2] = (sa[2] + sb[2] + 1) % 128;
      sa[4] = 33;
      ss[4] = sa[4] + sb[4];
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v = '0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_a = W'(sa[i]); in_b = W'(sb[i]); in_sum = (W + 1)'(ss[i]);
         @(negedge clk);
      end
      get_outs(0);
      chk("pre_rst.seq", 32'(o_seq), 1);
      chk("pre_rst.fval", 32'(o_fval), 1);
      in_a = W'(sa[10]); in_b = W'(sb[10]); in_sum = (W + 1)'(ss[10]);
      #2 rstn = 1'b0;
      #1 chk_zero(0, "midrst");
      in_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      idle_pulses(4);
      chk_zero(0, "idle_pulses");

      fill_lin(32);
      run(0, 32, 1'b1, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
